riscv_memory: RTL
=================

RISCV_MEMORY -- requirements
Module: riscv_memory

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the data and address width.
REQ-002 SHALL have parameter DEPTH, default 1024, giving the number of XLEN-bit words (power of two).
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port pc, input, XLEN, fetch byte address from the hart.
REQ-006 SHALL have port instruction, output, 32, fetched word.
REQ-007 SHALL have port mem_addr, input, XLEN, data byte address.
REQ-008 SHALL have port mem_data, input, XLEN, store data.
REQ-009 SHALL have port mem_write, input, 1, store strobe.
REQ-010 SHALL have port mem_read, output, XLEN, load data.
REQ-011 SHALL have ports load_valid (input, 1), load_ready (output, 1), load_data (input, XLEN) and load_last (input, 1), forming the program-loader handshake.
REQ-012 SHALL have port reload, input, 1, a pulse that restarts program load.
REQ-013 SHALL have ports hart_rst (output, 1, holds the hart in reset) and fault (output, 1, sticky access fault).

Function
REQ-014 SHALL use an FSM with states LOAD, RUN and HALT, resetting to LOAD.
REQ-015 In LOAD: load_ready=1 and hart_rst=1; each beat with load_valid&&load_ready writes load_data to word[ptr] and increments ptr.
REQ-016 SHALL go LOAD->RUN on an accepted beat with load_last=1, or on an accepted beat at ptr=DEPTH-1; ptr SHALL NOT wrap.
REQ-017 In RUN: load_ready=0, hart_rst=0, and load_valid is ignored.
REQ-018 The word index SHALL be addr[$clog2(DEPTH)+1:2]; an address is in range iff addr < DEPTH*4.
REQ-019 Reads SHALL be combinational (zero latency): instruction=word[pc index] and mem_read=word[mem_addr index]; an out-of-range address reads 0.
REQ-020 In RUN, mem_write=1 with an in-range, word-aligned mem_addr SHALL write mem_data at the next posedge; the new value is readable from the following cycle, with no forwarding.
REQ-021 In RUN, a fault event is: mem_write=1 with mem_addr[1:0]!=0 or out of range, or pc[1:0]!=0, or pc out of range. The faulting write SHALL be suppressed.
REQ-022 A fault event SHALL set fault=1 and move RUN->HALT at the next posedge; HALT asserts hart_rst=1 and load_ready=0.
REQ-023 reload=1 in any state SHALL, at the next posedge, go to LOAD with ptr=0 and clear fault; memory contents are retained until overwritten.
REQ-024 If reload and a store or load beat occur in the same cycle, reload wins and the write is dropped.
REQ-025 In LOAD and HALT, mem_write SHALL be ignored and SHALL NOT raise fault.

Reset
REQ-026 rst SHALL asynchronously force state=LOAD, ptr=0, fault=0, hart_rst=1, load_ready=1.
REQ-027 The memory array SHALL NOT be cleared by rst.
REQ-028 rst asserted mid-load SHALL abandon the load; loading restarts at ptr=0.

Configuration
REQ-029 Macro RISCV_MEM_MMIO_EN SHALL, when defined, add outputs console_valid (1) and console_data (8).
REQ-030 With RISCV_MEM_MMIO_EN, an aligned RUN store to 0xFFFF_FFF0 SHALL pulse console_valid for one cycle with console_data=mem_data[7:0] (registered); it SHALL neither write the array nor raise fault, and reads of that address return 0.
REQ-031 Without RISCV_MEM_MMIO_EN, those ports SHALL be absent and 0xFFFF_FFF0 SHALL be treated as out of range.

Structure
REQ-032 The FSM state enum (mem_state_t) and the MMIO address constant SHALL live in the shared riscv package, alongside the ISA types.
REQ-033 SHALL contain one sub-module, riscv_memory_loader, holding the FSM, ptr and handshake; the array and read/write decode stay in the top module.

Verification
REQ-034 Load: three beats 0x00000013, 0x00100093, 0x00000063 (last=1) -> state RUN, hart_rst=0; pc=4 gives instruction=0x00100093.
REQ-035 Store/load: RUN, mem_write=1, mem_addr=0x100, mem_data=0xDEADBEEF -> from the next cycle, mem_addr=0x100 gives mem_read=0xDEADBEEF.
REQ-036 Misaligned store: mem_addr=0x102 -> fault=1, state HALT, hart_rst=1, word 0x100 unchanged.
REQ-037 Out-of-range pc: pc=DEPTH*4 -> instruction=0, fault=1 at the next posedge.
REQ-038 Reload: in HALT, pulse reload and load one beat with last=1 -> fault=0, state RUN, word0 updated, word1 retained.
REQ-039 Mid-load rst: assert rst after 2 beats -> ptr=0, load_ready=1 with no clk edge required.

Source files
------------

// File: rtl/riscv_memory_pkg.sv
// Shared RISC-V types: ISA opcodes, memory/loader FSM states and the console MMIO address.
package riscv_memory_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_OP_IMM = 7'b0010011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } mem_state_t;

  localparam logic [31:0] MMIO_CONSOLE_ADDR = 32'hFFFF_FFF0;

  function automatic logic addr_aligned(input logic [1:0] lo);
    return lo == 2'b00;
  endfunction

endpackage

// File: rtl/riscv_memory_loader.sv
// Program-loader FSM: owns the LOAD/RUN/HALT state, the load pointer, the sticky fault and hart reset.
module riscv_memory_loader
  import riscv_memory_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reload,
  input  logic          load_valid,
  input  logic          load_last,
  input  logic          fault_event,
  output mem_state_t    state,
  output logic [AW-1:0] ptr,
  output logic          load_ready,
  output logic          hart_rst,
  output logic          fault,
  output logic          load_we
);

  localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

  mem_state_t    state_r;
  logic [AW-1:0] ptr_r;
  logic          load_ready_r;
  logic          hart_rst_r;
  logic          fault_r;

  // Reload outranks any beat arriving in the same cycle.
  assign load_we    = load_valid && load_ready_r && !reload;
  assign state      = state_r;
  assign ptr        = ptr_r;
  assign load_ready = load_ready_r;
  assign hart_rst   = hart_rst_r;
  assign fault      = fault_r;

  // State, pointer and registered handshake/control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= LOAD;
      ptr_r        <= {AW{1'b0}};
      fault_r      <= 1'b0;
      hart_rst_r   <= 1'b1;
      load_ready_r <= 1'b1;
    end else if (reload) begin
      state_r      <= LOAD;
      ptr_r        <= {AW{1'b0}};
      fault_r      <= 1'b0;
      hart_rst_r   <= 1'b1;
      load_ready_r <= 1'b1;
    end else begin
      case (state_r)
        LOAD: begin
          if (load_valid && load_ready_r) begin
            // The last word of the array ends the load; the pointer never wraps.
            if (load_last || (ptr_r == PTR_MAX)) begin
              state_r      <= RUN;
              hart_rst_r   <= 1'b0;
              load_ready_r <= 1'b0;
            end else begin
              ptr_r <= ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
          end
        end
        RUN: begin
          if (fault_event) begin
            state_r    <= HALT;
            fault_r    <= 1'b1;
            hart_rst_r <= 1'b1;
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r      <= LOAD;
          ptr_r        <= {AW{1'b0}};
          hart_rst_r   <= 1'b1;
          load_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/riscv_memory.sv
// Unified instruction/data memory with program loader and access-fault halt.
// Define RISCV_MEM_MMIO_EN to add a byte console at MMIO_CONSOLE_ADDR.
module riscv_memory
  import riscv_memory_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [31:0]     instruction,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_write,
  output logic [XLEN-1:0] mem_read,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [XLEN-1:0] load_data,
  input  logic            load_last,
  input  logic            reload,
  output logic            hart_rst,
  output logic            fault
`ifdef RISCV_MEM_MMIO_EN
  , output logic          console_valid,
  output logic [7:0]      console_data
`endif
);

  localparam int AW = $clog2(DEPTH);

  // In range iff every bit above the word index is zero, i.e. addr < DEPTH*4.
  function automatic logic in_range(input logic [XLEN-1:0] a);
    return a[XLEN-1:AW+2] == {(XLEN-AW-2){1'b0}};
  endfunction

  logic [XLEN-1:0] mem_r [DEPTH];

  mem_state_t    state_s;
  logic [AW-1:0] ptr_s;
  logic [AW-1:0] pc_idx_s;
  logic [AW-1:0] mem_idx_s;
  logic          pc_ok_s;
  logic          addr_ok_s;
  logic          load_we_s;
  logic          store_we_s;
  logic          fault_event_s;
  logic          mmio_hit_s;

  assign pc_idx_s  = pc[AW+1:2];
  assign mem_idx_s = mem_addr[AW+1:2];
  assign pc_ok_s   = in_range(pc);
  assign addr_ok_s = in_range(mem_addr);

  assign instruction = pc_ok_s   ? mem_r[pc_idx_s][31:0] : 32'd0;
  assign mem_read    = addr_ok_s ? mem_r[mem_idx_s]      : {XLEN{1'b0}};

  // Store and fault decode; only RUN stores can write the array or fault.
  always_comb begin
    store_we_s    = 1'b0;
    fault_event_s = 1'b0;
    mmio_hit_s    = 1'b0;
`ifdef RISCV_MEM_MMIO_EN
    mmio_hit_s = (state_s == RUN) && mem_write && (mem_addr == XLEN'(MMIO_CONSOLE_ADDR));
`endif
    if (state_s == RUN) begin
      store_we_s = mem_write && addr_aligned(mem_addr[1:0]) && addr_ok_s && !reload;
      if (mem_write && !mmio_hit_s && (!addr_aligned(mem_addr[1:0]) || !addr_ok_s)) begin
        fault_event_s = 1'b1;
      end else if (!addr_aligned(pc[1:0]) || !pc_ok_s) begin
        fault_event_s = 1'b1;
      end else begin
        fault_event_s = 1'b0;
      end
    end else begin
      store_we_s    = 1'b0;
      fault_event_s = 1'b0;
    end
  end

  // Array write port; contents survive rst and reload.
  always_ff @(posedge clk) begin
    if (load_we_s) begin
      mem_r[ptr_s] <= load_data;
    end else if (store_we_s) begin
      mem_r[mem_idx_s] <= mem_data;
    end
  end

`ifdef RISCV_MEM_MMIO_EN
  logic       console_valid_r;
  logic [7:0] console_data_r;

  // One-cycle console strobe with the stored byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      console_valid_r <= 1'b0;
      console_data_r  <= 8'd0;
    end else begin
      console_valid_r <= mmio_hit_s && !reload;
      console_data_r  <= mmio_hit_s ? mem_data[7:0] : console_data_r;
    end
  end

  assign console_valid = console_valid_r;
  assign console_data  = console_data_r;
`endif

  riscv_memory_loader #(
    .DEPTH (DEPTH)
  ) u_loader (
    .clk         (clk),
    .rst         (rst),
    .reload      (reload),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .fault_event (fault_event_s),
    .state       (state_s),
    .ptr         (ptr_s),
    .load_ready  (load_ready),
    .hart_rst    (hart_rst),
    .fault       (fault),
    .load_we     (load_we_s)
  );

endmodule
